valu_wb_buffer: RTL and testbench
=================================

Name: valu_wb_buffer

Overview:
- Writeback stage for the Dragon Core VALU; sits directly downstream of the execute stage.
- Captures each VALU result with its scoreboard transaction ID and holds it in a small FIFO.
- Presents results to a dedicated scoreboard writeback port using a valid/ack handshake.
- Drives the VALU ready signal back to issue, so back-pressure from writeback is never lost.

Parameters:
- DEPTH, 2, number of buffered results; power of two, at least 2.
- XLEN, 64, scoreboard writeback data width.
- TRANS_ID_BITS, 3, scoreboard transaction ID width; instantiated with ariane_pkg::TRANS_ID_BITS.
- SIGN_EXT, 1, 1 = sign-extend the 32-bit VALU result to XLEN; 0 = zero-extend.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  pipeline flush from controller.
- valu_valid_i  in  1  VALU result valid this cycle; issue only raises it while valu_ready_o is high.
- valu_result_i  in  32  combinational VALU result.
- valu_trans_id_i  in  TRANS_ID_BITS  scoreboard entry of the issuing instruction.
- valu_ready_o  out  1  buffer can accept a result this cycle.
- wb_valid_o  out  1  head entry valid toward scoreboard.
- wb_result_o  out  XLEN  head entry result, extended.
- wb_trans_id_o  out  TRANS_ID_BITS  head entry transaction ID.
- wb_ack_i  in  1  scoreboard accepted the head entry this cycle.
- overflow_o  out  1  sticky error: valid arrived while not ready.

Behaviour:
- Reset (async, rst_ni low):
  - read pointer, write pointer and count all 0.
  - overflow_o = 0; wb_valid_o = 0; wb_result_o = 0; wb_trans_id_o = 0.
  - storage contents are don't-care.
  - A reset mid-operation discards all entries immediately.
- Storage:
  - DEPTH entries of {XLEN result, trans_id}.
  - Pointers are log2(DEPTH) bits, wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Extension: applied on push.
  - SIGN_EXT=1: bits XLEN-1:32 = valu_result_i[31].
  - SIGN_EXT=0: bits XLEN-1:32 = 0.
  - When XLEN=32, no extension is applied.
- valu_ready_o = (count < DEPTH). Purely from registered state; no combinational path from wb_ack_i.
- Push: valu_valid_i & valu_ready_o & ~flush_i.
  - Writes the entry at the write pointer and increments the write pointer.
- Pop: wb_valid_o & wb_ack_i & ~flush_i.
  - Increments the read pointer.
- Count: next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - This is legal at any count below DEPTH.
- Full (count = DEPTH):
  - valu_ready_o = 0; a pop this cycle does not enable a same-cycle push.
  - A valid arriving while full sets overflow_o at the next edge; the data is dropped and state is unchanged.
- Output:
  - wb_valid_o = (count != 0).
  - wb_result_o and wb_trans_id_o are driven from the head entry and are 0 when empty.
  - No bypass: latency from push edge to wb_valid_o is 1 cycle.
  - The head stays stable while wb_valid_o is high and wb_ack_i is low.
- Ordering: strict FIFO; results retire in issue order.
- flush_i, at the next edge:
  - pointers and count go to 0.
  - push and pop in the same cycle are ignored.
  - overflow_o is NOT cleared; it clears only on reset.
- Empty with wb_ack_i high: ignored; no underflow.

Decomposition:
- Shared package (ariane_pkg): reuse TRANS_ID_BITS.
- Add a typedef valu_wb_entry_t {logic [XLEN-1:0] result; logic [TRANS_ID_BITS-1:0] trans_id;} to the Dragon Core VALU section of the package.
- One natural sub-module: valu_wb_fifo, a generic pointer/count FIFO with a flush port. Push/pop qualification, extension and the overflow flag stay in the top module.

Test Plan:
- Single push: valu_valid_i=1, result=0x8000_0001, id=5, ack held 1.
  - -> next cycle wb_valid_o=1, wb_result_o=0xFFFF_FFFF_8000_0001 (SIGN_EXT=1), wb_trans_id_o=5.
  - -> following cycle wb_valid_o=0.
- Fill and back-pressure: ack=0, push ids 1 and 2.
  - -> valu_ready_o=0 after the second edge.
  - -> head stays id 1 for 4 cycles.
  - -> one ack pops id 1, then valu_ready_o=1 and head = id 2.
- Simultaneous push/pop at count=1: ack=1 and push id 3 in the same cycle.
  - -> count stays 1; head = id 3 next cycle.
  - -> pointer wrap is exercised across 10 such cycles with no ID loss.
- Overflow: push while count=DEPTH.
  - -> overflow_o=1 next cycle, stored entries unchanged.
  - -> overflow_o remains 1 after a flush.
- Flush with 2 entries plus a same-cycle push.
  - -> next cycle count=0, wb_valid_o=0, valu_ready_o=1.
  - -> the pushed entry never appears.
- Async reset asserted mid-cycle with 2 entries.
  - -> wb_valid_o=0 and overflow_o=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared core package: scoreboard sizing and the Dragon Core VALU writeback entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ariane_pkg;

    // Scoreboard transaction ID width shared by all writeback ports.
    localparam int unsigned TRANS_ID_BITS = 3;

    // ---------------------------------------------------------------
    // Dragon Core VALU
    // ---------------------------------------------------------------
    localparam int unsigned VALU_WB_XLEN = 64;

    typedef struct packed {
        logic [VALU_WB_XLEN-1:0]  result;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } valu_wb_entry_t;

endpackage

// File: rtl/valu_wb_buffer_if.sv
// VALU-to-scoreboard writeback bundle: issue-side result handshake plus scoreboard valid/ack port.
// Latency: n/a (wires only).
// Backpressure: valu_ready_o throttles issue; wb_ack_i retires the head entry.
interface valu_wb_buffer_if
    import ariane_pkg::*;
#(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = ariane_pkg::TRANS_ID_BITS
);
    logic                     valu_valid_i;
    logic [31:0]              valu_result_i;
    logic [TRANS_ID_BITS-1:0] valu_trans_id_i;
    logic                     valu_ready_o;
    logic                     wb_valid_o;
    logic [XLEN-1:0]          wb_result_o;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
    logic                     wb_ack_i;
    logic                     overflow_o;

    // Environment side: execute stage and scoreboard.
    modport master (
        output valu_valid_i, valu_result_i, valu_trans_id_i, wb_ack_i,
        input  valu_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, overflow_o
    );

    // Buffer side.
    modport slave (
        input  valu_valid_i, valu_result_i, valu_trans_id_i, wb_ack_i,
        output valu_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, overflow_o
    );
endinterface

// File: rtl/valu_wb_fifo.sv
// Generic pointer/count FIFO with synchronous flush; head is read combinationally from storage.
// Latency: 1 cycle from push edge to entry visible at the head; no bypass.
// Backpressure: caller must qualify push with ~full and pop with ~empty.
module valu_wb_fifo #(
    parameter int unsigned WIDTH = 67,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage needs no reset: entries are only observed once count says they are live.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); flush drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/valu_wb_buffer.sv
// VALU writeback buffer: extends and queues results with their trans IDs, presents them to the scoreboard.
// Latency: 1 cycle from accepted result to wb_valid_o; results retire strictly in issue order.
// Backpressure: valu_ready_o = not full (registered state only); a valid while full is dropped and flagged sticky.
module valu_wb_buffer
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = ariane_pkg::TRANS_ID_BITS,
    parameter bit          SIGN_EXT      = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    valu_wb_buffer_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } entry_t;

    entry_t           wr_entry;
    entry_t           head;
    logic [XLEN-1:0]  ext_result;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             overflow;

    // Widen the 32-bit VALU result on the way in so the stored entry is already scoreboard-ready.
    generate
        if (XLEN > 32) begin : g_ext
            always_comb begin
                ext_result = {{(XLEN-32){SIGN_EXT ? bus.valu_result_i[31] : 1'b0}},
                              bus.valu_result_i};
            end
        end else begin : g_noext
            always_comb begin
                ext_result = bus.valu_result_i;
            end
        end
    endgenerate

    // Handshake qualification; flush wins over both sides, and a pop never frees a slot for a same-cycle push.
    always_comb begin
        wr_entry.result   = ext_result;
        wr_entry.trans_id = bus.valu_trans_id_i;
        push              = bus.valu_valid_i & ~full & ~flush_i;
        pop               = ~empty & bus.wb_ack_i & ~flush_i;
    end

    valu_wb_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .flush (flush_i),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Sticky overflow: issue broke the ready contract; only reset clears it, flush does not.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow <= 1'b0;
        end else if (bus.valu_valid_i && full) begin
            overflow <= 1'b1;
        end
    end

    // Outputs are gated by occupancy so stale storage never leaks out, including during reset.
    always_comb begin
        bus.valu_ready_o  = ~full;
        bus.wb_valid_o    = ~empty;
        bus.wb_result_o   = empty ? '0 : head.result;
        bus.wb_trans_id_o = empty ? '0 : head.trans_id;
        bus.overflow_o    = overflow;
    end
endmodule

// File: tb/tb_valu_wb_buffer.sv
// Directed bench for valu_wb_buffer: single push, fill/back-pressure, wrap, overflow, flush, async reset.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: ack is driven directly from the stimulus sequence.
module tb_valu_wb_buffer;
    logic clk_i;
    logic rst_ni;
    logic flush_i;

    int checks;
    int failures;

    valu_wb_buffer_if #(.XLEN(64), .TRANS_ID_BITS(3)) bus ();

    valu_wb_buffer #(
        .DEPTH         (2),
        .XLEN          (64),
        .TRANS_ID_BITS (3),
        .SIGN_EXT      (1'b1)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] res, input logic [2:0] id);
        bus.valu_valid_i    = vld;
        bus.valu_result_i   = res;
        bus.valu_trans_id_i = id;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_ni   = 1'b0;
        flush_i  = 1'b0;
        bus.wb_ack_i = 1'b0;
        drive(1'b0, 32'h0, 3'd0);
        #2;
        check("rst_wb_valid", {63'b0, bus.wb_valid_o}, 64'd0);
        check("rst_result",   bus.wb_result_o, 64'd0);
        check("rst_id",       {61'b0, bus.wb_trans_id_o}, 64'd0);
        check("rst_overflow", {63'b0, bus.overflow_o}, 64'd0);
        check("rst_ready",    {63'b0, bus.valu_ready_o}, 64'd1);
        #10;
        rst_ni = 1'b1;
        step();

        // Single push with ack held high; the ack at the push edge hits an empty buffer.
        bus.wb_ack_i = 1'b1;
        drive(1'b1, 32'h8000_0001, 3'd5);
        step();
        drive(1'b0, 32'h0, 3'd0);
        check("single_vld",    {63'b0, bus.wb_valid_o}, 64'd1);
        check("single_result", bus.wb_result_o, 64'hFFFF_FFFF_8000_0001);
        check("single_id",     {61'b0, bus.wb_trans_id_o}, 64'd5);
        step();
        check("single_drain",  {63'b0, bus.wb_valid_o}, 64'd0);

        // Fill and back-pressure.
        bus.wb_ack_i = 1'b0;
        drive(1'b1, 32'h0000_0011, 3'd1);
        step();
        check("fill1_ready", {63'b0, bus.valu_ready_o}, 64'd1);
        drive(1'b1, 32'h0000_0022, 3'd2);
        step();
        drive(1'b0, 32'h0, 3'd0);
        check("fill2_ready", {63'b0, bus.valu_ready_o}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_id",  {61'b0, bus.wb_trans_id_o}, 64'd1);
            check("hold_res", bus.wb_result_o, 64'h11);
        end
        bus.wb_ack_i = 1'b1;
        step();
        bus.wb_ack_i = 1'b0;
        check("pop_ready", {63'b0, bus.valu_ready_o}, 64'd1);
        check("pop_id",    {61'b0, bus.wb_trans_id_o}, 64'd2);
        check("pop_res",   bus.wb_result_o, 64'h22);

        // Simultaneous push/pop at count=1, then wrap across 10 more cycles.
        bus.wb_ack_i = 1'b1;
        drive(1'b1, 32'h7FFF_FFFF, 3'd3);
        step();
        check("pp_id",    {61'b0, bus.wb_trans_id_o}, 64'd3);
        check("pp_res",   bus.wb_result_o, 64'h0000_0000_7FFF_FFFF);
        check("pp_ready", {63'b0, bus.valu_ready_o}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            logic [2:0] id;
            id = 3'((i + 4) % 8);
            drive(1'b1, 32'(i), id);
            step();
            check("wrap_id",  {61'b0, bus.wb_trans_id_o}, {61'b0, id});
            check("wrap_res", bus.wb_result_o, 64'(i));
            check("wrap_vld", {63'b0, bus.wb_valid_o}, 64'd1);
        end
        drive(1'b0, 32'h0, 3'd0);
        step();
        check("wrap_empty", {63'b0, bus.wb_valid_o}, 64'd0);

        // Overflow while full.
        bus.wb_ack_i = 1'b0;
        drive(1'b1, 32'h0000_0AAA, 3'd1);
        step();
        drive(1'b1, 32'h0000_0BBB, 3'd2);
        step();
        check("ovf_pre", {63'b0, bus.overflow_o}, 64'd0);
        drive(1'b1, 32'h0000_DEAD, 3'd7);
        step();
        drive(1'b0, 32'h0, 3'd0);
        check("ovf_set",  {63'b0, bus.overflow_o}, 64'd1);
        check("ovf_head", {61'b0, bus.wb_trans_id_o}, 64'd1);
        check("ovf_res",  bus.wb_result_o, 64'hAAA);
        bus.wb_ack_i = 1'b1;
        step();
        bus.wb_ack_i = 1'b0;
        check("ovf_second", {61'b0, bus.wb_trans_id_o}, 64'd2);
        check("ovf_second_res", bus.wb_result_o, 64'hBBB);
        drive(1'b1, 32'h0000_0066, 3'd6);
        step();
        drive(1'b0, 32'h0, 3'd0);
        check("refill_ready", {63'b0, bus.valu_ready_o}, 64'd0);

        // Flush with 2 entries and valid + ack asserted.
        flush_i = 1'b1;
        bus.wb_ack_i = 1'b1;
        drive(1'b1, 32'h0000_0044, 3'd4);
        step();
        flush_i = 1'b0;
        bus.wb_ack_i = 1'b0;
        drive(1'b0, 32'h0, 3'd0);
        check("flush_vld",   {63'b0, bus.wb_valid_o}, 64'd0);
        check("flush_ready", {63'b0, bus.valu_ready_o}, 64'd1);
        check("flush_ovf",   {63'b0, bus.overflow_o}, 64'd1);
        check("flush_res",   bus.wb_result_o, 64'd0);
        step();
        check("flush_after", {63'b0, bus.wb_valid_o}, 64'd0);

        // Flush at count=1 with a legal same-cycle push: that push is dropped.
        drive(1'b1, 32'h0000_0033, 3'd3);
        step();
        check("f1_vld", {63'b0, bus.wb_valid_o}, 64'd1);
        flush_i = 1'b1;
        bus.wb_ack_i = 1'b1;
        drive(1'b1, 32'h0000_0055, 3'd5);
        step();
        flush_i = 1'b0;
        bus.wb_ack_i = 1'b0;
        drive(1'b0, 32'h0, 3'd0);
        check("f1_flush_vld", {63'b0, bus.wb_valid_o}, 64'd0);
        step();
        check("f1_never", {63'b0, bus.wb_valid_o}, 64'd0);

        // Async reset mid-cycle with 2 entries.
        drive(1'b1, 32'h0000_0001, 3'd1);
        step();
        drive(1'b1, 32'h0000_0002, 3'd2);
        step();
        drive(1'b0, 32'h0, 3'd0);
        check("pre_rst_vld", {63'b0, bus.wb_valid_o}, 64'd1);
        check("pre_rst_ovf", {63'b0, bus.overflow_o}, 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_vld",   {63'b0, bus.wb_valid_o}, 64'd0);
        check("arst_ovf",   {63'b0, bus.overflow_o}, 64'd0);
        check("arst_ready", {63'b0, bus.valu_ready_o}, 64'd1);
        check("arst_res",   bus.wb_result_o, 64'd0);
        #3;
        rst_ni = 1'b1;
        step();
        check("post_rst_vld", {63'b0, bus.wb_valid_o}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
